dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: 256x32 RAM, GPIO and optional 64-bit machine timer; zero-wait combinational reads, writes land at the clock edge.
// Timer block (MTIME/MTIMECMP/TCTRL/timer_irq) exists only with DMEM_RESPONDER_TIMER_EN; otherwise its addresses decode as unmapped.
module dmem_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic [7:0]  gpio_out,
    output logic        timer_irq,
    output logic        bus_err
);
    localparam logic [29:0] A_MTIME_LO = 30'h0000_4000;
    localparam logic [29:0] A_MTIME_HI = 30'h0000_4001;
    localparam logic [29:0] A_CMP_LO   = 30'h0000_4002;
    localparam logic [29:0] A_CMP_HI   = 30'h0000_4003;
    localparam logic [29:0] A_TCTRL    = 30'h0000_4004;
    localparam logic [29:0] A_GPIO     = 30'h0000_4005;

    logic [29:0] word_addr;
    logic        unused_addr_lsb;
    logic        sel_ram;
    logic        sel_gpio;
    logic        sel_tmr;
    logic        mapped;

    logic [31:0] mem_q [256];
    logic [7:0]  gpio_q;
    logic        bus_err_q;

    assign word_addr       = Mem_WrAddr[31:2];
    assign unused_addr_lsb = ^Mem_WrAddr[1:0];
    assign sel_ram         = (word_addr[29:8] == 22'd0);
    assign sel_gpio        = (word_addr == A_GPIO);
    assign mapped          = sel_ram | sel_gpio | sel_tmr;

`ifdef DMEM_RESPONDER_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        flag_q, flag_d;
    logic        flag_clr;

    assign sel_tmr = (word_addr >= A_MTIME_LO) && (word_addr <= A_TCTRL);

    // Software writes override the increment and carry nothing into the other half.
    always_comb begin
        mtime_d  = en_q ? (mtime_q + 64'd1) : mtime_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        flag_clr = 1'b0;
        if (MemWrite) begin
            case (word_addr)
                A_MTIME_LO: mtime_d = {mtime_q[63:32], Mem_WrData};
                A_MTIME_HI: mtime_d = {Mem_WrData, mtime_q[31:0]};
                A_CMP_LO:   cmp_d   = {cmp_q[63:32], Mem_WrData};
                A_CMP_HI:   cmp_d   = {Mem_WrData, cmp_q[31:0]};
                A_TCTRL: begin
                    en_d     = Mem_WrData[0];
                    flag_clr = Mem_WrData[1];
                end
                default: ;
            endcase
        end
        flag_d = (flag_q && !flag_clr) || (en_q && (mtime_q >= cmp_q));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime_q <= 64'd0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            flag_q  <= flag_d;
        end
    end

    assign timer_irq = flag_q;
`else
    assign sel_tmr   = 1'b0;
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        ReadData = 32'd0;
        if (sel_ram)  ReadData = mem_q[word_addr[7:0]];
        if (sel_gpio) ReadData = {24'd0, gpio_q};
`ifdef DMEM_RESPONDER_TIMER_EN
        case (word_addr)
            A_MTIME_LO: ReadData = mtime_q[31:0];
            A_MTIME_HI: ReadData = mtime_q[63:32];
            A_CMP_LO:   ReadData = cmp_q[31:0];
            A_CMP_HI:   ReadData = cmp_q[63:32];
            A_TCTRL:    ReadData = {30'd0, flag_q, en_q};
            default: ;
        endcase
`endif
    end

    // RAM contents deliberately survive reset; only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (reset && MemWrite && sel_ram)
            mem_q[word_addr[7:0]] <= Mem_WrData;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_q    <= 8'h00;
            bus_err_q <= 1'b0;
        end else begin
            if (MemWrite && sel_gpio) gpio_q <= Mem_WrData[7:0];
            if (!mapped) bus_err_q <= 1'b1;
        end
    end

    assign gpio_out = gpio_q;
    assign bus_err  = bus_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench: stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_dmem_responder;
    localparam logic [31:0] MTLO  = 32'h0001_0000;
    localparam logic [31:0] MTHI  = 32'h0001_0004;
    localparam logic [31:0] CMPLO = 32'h0001_0008;
    localparam logic [31:0] CMPHI = 32'h0001_000C;
    localparam logic [31:0] TCTRL = 32'h0001_0010;
    localparam logic [31:0] GPIO  = 32'h0001_0014;

    localparam int S_RD   = 0;
    localparam int S_GPIO = 1;
    localparam int S_IRQ  = 2;
    localparam int S_BERR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = 32'd0;
    logic [31:0] Mem_WrData = 32'd0;
    logic [31:0] ReadData;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    logic        bus_err;

    dmem_responder dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData),
        .ReadData(ReadData),
        .gpio_out(gpio_out),
        .timer_irq(timer_irq),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          cyc_q [$];
    int          sel_q [$];
    logic [31:0] exp_q [$];
    string       name_q [$];

    int errors = 0;
    int checks = 0;

    int          m_cyc;
    int          m_sel;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;

    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            m_cyc  = cyc_q.pop_front();
            m_sel  = sel_q.pop_front();
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            case (m_sel)
                S_RD:    m_act = ReadData;
                S_GPIO:  m_act = {24'd0, gpio_out};
                S_IRQ:   m_act = {31'd0, timer_irq};
                default: m_act = {31'd0, bus_err};
            endcase
            checks++;
            if (m_cyc != cyc) begin
                errors++;
                $display("FAIL %s: stale expectation from cycle %0d seen at cycle %0d", m_name, m_cyc, cyc);
            end else if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", m_name, cyc, m_act, m_exp);
            end
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset      = rst;
        MemWrite   = we;
        Mem_WrAddr = a;
        Mem_WrData = d;
    endtask

    task automatic exp_push(input int sel, input logic [31:0] v, input string nm);
        cyc_q.push_back(cyc);
        sel_q.push_back(sel);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset cycles, with a GPIO write that must be ignored
        drive(1'b0, 1'b1, GPIO, 32'h0000_00FF);
        drive(1'b0, 1'b0, 32'd0, 32'd0);

        drive(1'b1, 1'b0, GPIO, 32'd0);
        exp_push(S_RD,   32'd0, "reset_gpio_read");
        exp_push(S_GPIO, 32'd0, "reset_gpio_out");
        exp_push(S_IRQ,  32'd0, "reset_irq");
        exp_push(S_BERR, 32'd0, "reset_bus_err");

        drive(1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678);
        drive(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        exp_push(S_RD, 32'hDEAD_BEEF, "ram_0x40");
        drive(1'b1, 1'b0, 32'h0000_0044, 32'd0);
        exp_push(S_RD, 32'h1234_5678, "ram_0x44_unchanged");

        drive(1'b1, 1'b1, GPIO, 32'h0000_01A5);
        exp_push(S_GPIO, 32'd0, "gpio_pre_edge");
        drive(1'b1, 1'b0, GPIO, 32'd0);
        exp_push(S_RD,   32'h0000_00A5, "gpio_read");
        exp_push(S_GPIO, 32'h0000_00A5, "gpio_out");

        drive(1'b1, 1'b1, 32'h0000_03FF, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 32'h0000_03FC, 32'd0);
        exp_push(S_RD,   32'hCAFE_F00D, "ram_top_word");
        exp_push(S_BERR, 32'd0, "ram_top_mapped");

`ifdef DMEM_RESPONDER_TIMER_EN
        drive(1'b1, 1'b1, CMPLO, 32'd10);
        drive(1'b1, 1'b1, CMPHI, 32'd0);
        drive(1'b1, 1'b1, TCTRL, 32'd1);
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, MTLO, 32'd0);
            exp_push(S_RD,  k, "mtime_count");
            exp_push(S_IRQ, (k >= 11) ? 32'd1 : 32'd0, "irq_rise");
        end
        drive(1'b1, 1'b1, TCTRL, 32'd3);
        exp_push(S_IRQ, 32'd1, "irq_before_w1c");
        drive(1'b1, 1'b0, TCTRL, 32'd0);
        exp_push(S_RD,  32'd3, "tctrl_set_wins");
        exp_push(S_IRQ, 32'd1, "irq_set_wins");
        drive(1'b1, 1'b1, CMPHI, 32'd1);
        drive(1'b1, 1'b1, TCTRL, 32'd3);
        exp_push(S_RD, 32'd3, "tctrl_before_clear");
        drive(1'b1, 1'b0, TCTRL, 32'd0);
        exp_push(S_RD,  32'd1, "tctrl_cleared");
        exp_push(S_IRQ, 32'd0, "irq_cleared");

        drive(1'b1, 1'b1, MTLO, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, MTHI, 32'hFFFF_FFFF);
        exp_push(S_RD, 32'd0, "mtime_hi_held");
        drive(1'b1, 1'b0, MTLO, 32'd0);
        exp_push(S_RD,  32'hFFFF_FFFF, "mtime_lo_no_carry");
        exp_push(S_IRQ, 32'd0, "irq_below_cmp");
        drive(1'b1, 1'b0, MTLO, 32'd0);
        exp_push(S_RD,  32'd0, "mtime_lo_wrap");
        exp_push(S_IRQ, 32'd1, "irq_after_max");
        drive(1'b1, 1'b0, MTHI, 32'd0);
        exp_push(S_RD, 32'd0, "mtime_hi_wrap");
`endif

        drive(1'b1, 1'b1, 32'h0002_0000, 32'h0000_00FF);
        exp_push(S_RD,   32'd0, "unmapped_read_zero");
        exp_push(S_BERR, 32'd0, "bus_err_pre_edge");
        drive(1'b1, 1'b0, GPIO, 32'd0);
        exp_push(S_RD,   32'h0000_00A5, "unmapped_no_gpio_change");
        exp_push(S_BERR, 32'd1, "bus_err_set");
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        exp_push(S_RD,   32'hDEAD_BEEF, "unmapped_no_ram_change");
        exp_push(S_BERR, 32'd1, "bus_err_sticky");
`ifdef DMEM_RESPONDER_TIMER_EN
        exp_push(S_IRQ, 32'd1, "irq_before_reset");
`endif

        drive(1'b0, 1'b1, GPIO, 32'h0000_0077);
        exp_push(S_BERR, 32'd1, "bus_err_until_reset");

        drive(1'b1, 1'b0, MTLO, 32'd0);
        exp_push(S_RD,   32'd0, "mtime_after_reset");
        exp_push(S_GPIO, 32'd0, "gpio_after_reset");
        exp_push(S_IRQ,  32'd0, "irq_after_reset");
        exp_push(S_BERR, 32'd0, "bus_err_after_reset");

`ifdef DMEM_RESPONDER_TIMER_EN
        drive(1'b1, 1'b0, MTLO, 32'd0);
        exp_push(S_RD,  32'd0, "count_aborted");
        exp_push(S_IRQ, 32'd0, "irq_stays_low");
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        exp_push(S_RD, 32'hDEAD_BEEF, "ram_survives_reset");
        drive(1'b1, 1'b0, 32'h0001_0018, 32'd0);
        exp_push(S_RD,   32'd0, "load_unmapped_zero");
        exp_push(S_BERR, 32'd0, "load_err_pre_edge");
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        exp_push(S_BERR, 32'd1, "load_err_set");
`else
        drive(1'b1, 1'b1, TCTRL, 32'd1);
        exp_push(S_RD,   32'd0, "timer_off_tctrl_zero");
        exp_push(S_BERR, 32'd1, "timer_off_load_err");
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        exp_push(S_RD,  32'hDEAD_BEEF, "ram_survives_reset");
        exp_push(S_IRQ, 32'd0, "timer_off_irq_low");
        drive(1'b1, 1'b0, TCTRL, 32'd0);
        exp_push(S_RD,  32'd0, "timer_off_tctrl_read");
        exp_push(S_IRQ, 32'd0, "timer_off_irq_still_low");
`endif

        drive(1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        if (cyc_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", cyc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
